// File: rtl/ro_odometer_ctrl_if.sv
// Odometer-side bus of the sequencing controller: stress/measure controls,
// RO selects and the returned frequency counts.
interface ro_odometer_ctrl_if #(
    parameter int MUX_SEL_SIZE = 3
);
    logic                    go;
    logic                    en_out;
    logic [MUX_SEL_SIZE-1:0] r_mux_sel;
    logic [MUX_SEL_SIZE-1:0] s_mux_sel;
    logic [31:0]             r_freq;
    logic [31:0]             s_freq;
    logic                    valid_out;

    modport master (
        output go, en_out, r_mux_sel, s_mux_sel,
        input  r_freq, s_freq, valid_out
    );

    modport slave (
        input  go, en_out, r_mux_sel, s_mux_sel,
        output r_freq, s_freq, valid_out
    );
endinterface

// File: rtl/ro_odometer_ctrl.sv
// Sweeps every CDIR sensor pair through stress / measure / capture and flags
// pairs whose reference-minus-stressed frequency drop exceeds a threshold.
module ro_odometer_ctrl #(
    parameter int NO_CDIR        = 8,
    parameter int MUX_SEL_SIZE   = $clog2(NO_CDIR),
    parameter int GO_CYCLES      = 5,
    parameter int STRESS_CYCLES  = 50,
    parameter int EN_CYCLES      = 5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [31:0]             thresh,
    ro_odometer_ctrl_if.master      odo,
    output logic                    busy,
    output logic                    result_valid,
    output logic [MUX_SEL_SIZE-1:0] result_idx,
    output logic [31:0]             result_diff,
    output logic                    result_flag,
    output logic                    recycled,
    output logic                    done,
    output logic                    timeout_err
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] GO         = 3'd1;
    localparam logic [2:0] STRESS     = 3'd2;
    localparam logic [2:0] MEAS       = 3'd3;
    localparam logic [2:0] WAIT_VALID = 3'd4;
    localparam logic [2:0] CAPTURE    = 3'd5;
    localparam logic [2:0] NEXT       = 3'd6;
    localparam logic [2:0] DONE       = 3'd7;

    localparam int CNT_MAX = (TIMEOUT_CYCLES > STRESS_CYCLES) ?
                             ((TIMEOUT_CYCLES > GO_CYCLES + EN_CYCLES) ? TIMEOUT_CYCLES : GO_CYCLES + EN_CYCLES) :
                             ((STRESS_CYCLES > GO_CYCLES + EN_CYCLES) ? STRESS_CYCLES : GO_CYCLES + EN_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [MUX_SEL_SIZE-1:0] LAST_IDX = MUX_SEL_SIZE'(NO_CDIR - 1);

    logic [2:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [MUX_SEL_SIZE-1:0] idx;
    logic                    armed;
    logic [31:0]             thresh_q;
    logic [31:0]             diff;
    logic                    flag;

    // Controls decode straight from the state register so an async reset
    // drops them without waiting for a clock.
    assign odo.go        = (state == GO);
    assign odo.en_out    = (state == MEAS);
    assign odo.r_mux_sel = idx;
    assign odo.s_mux_sel = idx;
    assign done          = (state == DONE);

    assign diff = (odo.r_freq >= odo.s_freq) ? (odo.r_freq - odo.s_freq) : 32'd0;
    assign flag = (diff > thresh_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            armed        <= 1'b0;
            thresh_q     <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_idx   <= '0;
            result_diff  <= '0;
            result_flag  <= 1'b0;
            recycled     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            cnt          <= cnt + 1'b1;
            // A valid_out low anywhere in the pair proves the odometer restarted,
            // so a level left over from the previous pair can't be captured.
            if ((state inside {GO, STRESS, MEAS, WAIT_VALID}) && !odo.valid_out)
                armed <= 1'b1;

            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        busy        <= 1'b1;
                        recycled    <= 1'b0;
                        timeout_err <= 1'b0;
                        idx         <= '0;
                        thresh_q    <= thresh;
                        cnt         <= '0;
                        armed       <= 1'b0;
                        state       <= GO;
                    end
                    GO: if (cnt == CNT_W'(GO_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= STRESS;
                    end
                    STRESS: if (cnt == CNT_W'(STRESS_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= MEAS;
                    end
                    MEAS: if (cnt == CNT_W'(EN_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= WAIT_VALID;
                    end
                    WAIT_VALID: begin
                        if (armed && odo.valid_out) begin
                            result_valid <= 1'b1;
                            result_idx   <= idx;
                            result_diff  <= diff;
                            result_flag  <= flag;
                            recycled     <= recycled | flag;
                            state        <= CAPTURE;
                        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err  <= 1'b1;
                            result_valid <= 1'b1;
                            result_idx   <= idx;
                            result_diff  <= '0;
                            result_flag  <= 1'b0;
                            cnt          <= '0;
                            state        <= NEXT;
                        end
                    end
                    CAPTURE: begin
                        cnt   <= '0;
                        state <= NEXT;
                    end
                    // Two cycles: the select moves in the first, go rises after
                    // the second, so the mux has settled a full cycle before stress.
                    NEXT: begin
                        if (cnt == '0) begin
                            if (idx == LAST_IDX) begin
                                busy  <= 1'b0;
                                state <= DONE;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt   <= '0;
                            armed <= 1'b0;
                            state <= GO;
                        end
                    end
                    DONE: begin
                        idx   <= '0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ro_odometer_ctrl.sv
// Directed bench for ro_odometer_ctrl with a behavioural odometer and a
// result scoreboard filled at start and drained against observed results.
module tb_ro_odometer_ctrl;
    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] thresh;
    logic        busy, result_valid, result_flag, recycled, done, timeout_err;
    logic [2:0]  result_idx;
    logic [31:0] result_diff;

    ro_odometer_ctrl_if #(.MUX_SEL_SIZE(3)) odo ();

    ro_odometer_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .thresh(thresh),
        .odo(odo), .busy(busy), .result_valid(result_valid), .result_idx(result_idx),
        .result_diff(result_diff), .result_flag(result_flag), .recycled(recycled),
        .done(done), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] diff;
        logic        flag;
    } res_t;

    logic [31:0] r_tab [8];
    logic [31:0] s_tab [8];
    logic        stuck;

    // Odometer model: counts become valid a few cycles after en_out falls and
    // stay valid until the next go (or forever when stuck).
    logic       en_d;
    logic [2:0] dly;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            odo.valid_out <= 1'b0;
            odo.r_freq    <= '0;
            odo.s_freq    <= '0;
            en_d          <= 1'b0;
            dly           <= '0;
        end else begin
            en_d <= odo.en_out;
            if (stuck) odo.valid_out <= 1'b1;
            else if (odo.go) odo.valid_out <= 1'b0;
            if (en_d && !odo.en_out) dly <= 3'd4;
            else if (dly != 0) begin
                dly <= dly - 1'b1;
                if (dly == 3'd1 && !stuck) begin
                    odo.valid_out <= 1'b1;
                    odo.r_freq    <= r_tab[odo.r_mux_sel];
                    odo.s_freq    <= s_tab[odo.s_mux_sel];
                end
            end
        end
    end

    // Observation monitor; written only here, read by the checking sequence.
    res_t obs [256];
    int   res_cnt = 0, done_cnt = 0, go_run = 0, go_bad = 0, ov_cnt = 0;
    always @(negedge clk) begin
        if (rst) go_run = 0;
        else begin
            if (odo.go && odo.en_out) ov_cnt++;
            if (odo.go) go_run++;
            else if (go_run != 0) begin
                if (go_run != 5) go_bad++;
                go_run = 0;
            end
            if (done) done_cnt++;
            if (result_valid) begin
                obs[res_cnt % 256] = '{idx: result_idx, diff: result_diff, flag: result_flag};
                res_cnt++;
            end
        end
    end

    int   checks = 0, errors = 0;
    res_t sb [$];
    int   rd = 0, res_base = 0, done_base = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    task automatic set_tabs(input logic [31:0] r, input logic [31:0] s);
        for (int i = 0; i < 8; i++) begin
            r_tab[i] = r;
            s_tab[i] = s;
        end
    endtask

    task automatic start_sweep(input logic [31:0] thr, input bit to_mode);
        logic [31:0] d;
        thresh    = thr;
        res_base  = res_cnt;
        rd        = res_cnt;
        done_base = done_cnt;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            d = (r_tab[i] >= s_tab[i]) ? r_tab[i] - s_tab[i] : 32'd0;
            if (to_mode) d = 32'd0;
            sb.push_back('{idx: 3'(i), diff: d, flag: (!to_mode && d > thr)});
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic drain(input int n);
        res_t e, o;
        for (int k = 0; k < n && rd < res_cnt && sb.size() > 0; k++) begin
            e = sb.pop_front();
            o = obs[rd % 256];
            rd++;
            chk("result_idx", 32'(o.idx), 32'(e.idx));
            chk("result_diff", o.diff, e.diff);
            chk("result_flag", 32'(o.flag), 32'(e.flag));
        end
    endtask

    task automatic finish_sweep(input int limit, input logic rec_e, input logic to_e);
        for (int i = 0; i < limit; i++) begin
            if (done_cnt != done_base) break;
            @(negedge clk);
        end
        chk("done_within_limit", 32'(done_cnt - done_base), 32'd1);
        repeat (5) @(negedge clk);
        chk("done_once", 32'(done_cnt - done_base), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("result_count", 32'(res_cnt - res_base), 32'd8);
        drain(8);
        chk("sb_left", 32'(sb.size()), 32'd0);
        chk("recycled", 32'(recycled), 32'(rec_e));
        chk("timeout_err", 32'(timeout_err), 32'(to_e));
        chk("go_len_bad", 32'(go_bad), 32'd0);
        chk("go_en_overlap", 32'(ov_cnt), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; thresh = '0; stuck = 1'b0;
        set_tabs(32'h100, 32'h0F0);
        repeat (3) @(negedge clk);
        chk("rst_go", 32'(odo.go), 32'd0);
        chk("rst_en", 32'(odo.en_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rvalid", 32'(result_valid), 32'd0);
        chk("rst_diff", result_diff, 32'd0);
        chk("rst_sel", 32'(odo.r_mux_sel), 32'd0);
        chk("rst_flags", 32'({recycled, timeout_err, result_flag}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // nominal sweep
        start_sweep(32'h20, 1'b0);
        @(negedge clk);
        chk("busy_running", 32'(busy), 32'd1);
        finish_sweep(2000, 1'b0, 1'b0);

        // detection on idx 5
        s_tab[5] = 32'h0C0;
        start_sweep(32'h20, 1'b0);
        finish_sweep(2000, 1'b1, 1'b0);

        // saturation, equal-to-threshold, just above threshold
        set_tabs(32'h100, 32'h0F0);
        r_tab[0] = 32'h50; s_tab[0] = 32'h60;
        r_tab[1] = 32'h30; s_tab[1] = 32'h20;
        r_tab[2] = 32'h31; s_tab[2] = 32'h20;
        start_sweep(32'h10, 1'b0);
        finish_sweep(2000, 1'b1, 1'b0);

        // maximal threshold never flags
        set_tabs(32'h100, 32'h0F0);
        r_tab[0] = 32'hFFFF_FFFF; s_tab[0] = 32'h0;
        start_sweep(32'hFFFF_FFFF, 1'b0);
        finish_sweep(2000, 1'b0, 1'b0);

        // permanently high valid_out: every pair must time out
        set_tabs(32'h100, 32'h0F0);
        stuck = 1'b1;
        start_sweep(32'h20, 1'b1);
        finish_sweep(40000, 1'b0, 1'b1);
        stuck = 1'b0;

        // abort during MEAS of idx 3
        start_sweep(32'h20, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (odo.en_out && odo.r_mux_sel == 3'd3) break;
            @(negedge clk);
        end
        chk("abort_reached_meas3", 32'({odo.en_out, odo.r_mux_sel}), 32'h0B);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_en", 32'(odo.en_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (300) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - done_base), 32'd0);
        chk("abort_results", 32'(res_cnt - res_base), 32'd3);
        drain(3);
        start_sweep(32'h20, 1'b0);
        finish_sweep(2000, 1'b0, 1'b0);

        // async reset while go is high
        start_sweep(32'h20, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (odo.go && odo.r_mux_sel == 3'd1) break;
            @(negedge clk);
        end
        chk("rst_reached_go", 32'(odo.go), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_go", 32'(odo.go), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // clean sweep with a stray start at idx 2
        start_sweep(32'h20, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (odo.go && odo.r_mux_sel == 3'd2) break;
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        finish_sweep(2000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
